// File: rtl/mgmt_gpio_arbiter_pkg.sv
// Shared definitions for the management GPIO arbiter: FSM encodings,
// default timing parameters and the shared-counter width helper.
package mgmt_gpio_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;

  localparam int DEF_TURN_CYC = 2;
  localparam int DEF_MAX_HOLD = 0;

  // One counter serves both the turnaround and the hold limit.
  function automatic int cnt_width(input int turn_cyc, input int max_hold);
    int top;
    top = (turn_cyc > max_hold) ? turn_cyc : max_hold;
    return (top < 1) ? 1 : $clog2(top + 1);
  endfunction

endpackage

// File: rtl/mgmt_gpio_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after the last winner,
// wrapping modulo NREQ. Zero latency, no backpressure.
module mgmt_gpio_rr_pick #(
  parameter int NREQ    = 3,
  parameter int OWNER_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]    req,
  input  logic [OWNER_W-1:0] last,
  output logic [NREQ-1:0]    win,
  output logic [OWNER_W-1:0] win_idx,
  output logic               any
);

  logic [OWNER_W-1:0] cand;

  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    cand    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = OWNER_W'((int'(last) + i) % NREQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        win_idx   = cand;
        win[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mgmt_gpio_arbiter.sv
// Round-robin owner of the shared management GPIO pins with forced high-Z
// turnaround between owners. Grant and pins follow requests by one cycle.
module mgmt_gpio_arbiter
  import mgmt_gpio_arbiter_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int NPINS    = 3,
  parameter int TURN_CYC = DEF_TURN_CYC,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  localparam int OWNER_W = $clog2(NREQ)
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [NREQ-1:0]         req_i,
  output logic [NREQ-1:0]         gnt_o,
  input  logic [NREQ*NPINS-1:0]   req_out_i,
  input  logic [NREQ*NPINS-1:0]   req_oeb_i,
  output logic [NREQ*NPINS-1:0]   req_in_o,
  input  logic [NPINS-1:0]        mgmt_gpio_in_i,
  output logic [NPINS-1:0]        mgmt_gpio_out_o,
  output logic [NPINS-1:0]        mgmt_gpio_oeb_o,
  output logic                    busy_o,
  output logic [OWNER_W-1:0]      owner_o,
  output logic                    timeout_o
);

  localparam int CNT_W = cnt_width(TURN_CYC, MAX_HOLD);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [OWNER_W-1:0] last;

  logic [NREQ-1:0]    pick_win;
  logic [OWNER_W-1:0] pick_idx;
  logic               pick_any;

  logic [NPINS-1:0]   out_s [NREQ];
  logic [NPINS-1:0]   oeb_s [NREQ];

  logic own_req, others, rel_now, pre_now, turn_done;

  mgmt_gpio_rr_pick #(.NREQ(NREQ), .OWNER_W(OWNER_W)) u_pick (
    .req     (req_i),
    .last    (last),
    .win     (pick_win),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  for (genvar k = 0; k < NREQ; k++) begin : g_slice
    assign out_s[k] = req_out_i[k*NPINS +: NPINS];
    assign oeb_s[k] = req_oeb_i[k*NPINS +: NPINS];
    assign req_in_o[k*NPINS +: NPINS] = mgmt_gpio_in_i & {NPINS{gnt_o[k]}};
  end

  assign own_req   = req_i[owner_o];
  assign others    = |(req_i & ~gnt_o);
  assign rel_now   = !own_req;
  assign pre_now   = (MAX_HOLD != 0) && (cnt == CNT_W'(MAX_HOLD)) && others;
  assign turn_done = (cnt == CNT_W'(TURN_CYC - 1));
  assign busy_o    = (state != ST_IDLE);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state           <= ST_IDLE;
      gnt_o           <= '0;
      mgmt_gpio_out_o <= '0;
      mgmt_gpio_oeb_o <= '1;
      owner_o         <= '0;
      timeout_o       <= 1'b0;
      last            <= OWNER_W'(NREQ - 1);
      cnt             <= '0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state           <= ST_GRANT;
            gnt_o           <= pick_win;
            owner_o         <= pick_idx;
            last            <= pick_idx;
            mgmt_gpio_out_o <= out_s[pick_idx];
            mgmt_gpio_oeb_o <= oeb_s[pick_idx];
            cnt             <= '0;
          end
        end
        ST_GRANT: begin
          if (rel_now || pre_now) begin
            // A simultaneous release is not reported as a timeout.
            state           <= ST_TURN;
            gnt_o           <= '0;
            mgmt_gpio_out_o <= '0;
            mgmt_gpio_oeb_o <= '1;
            cnt             <= '0;
            timeout_o       <= !rel_now;
          end else begin
            mgmt_gpio_out_o <= out_s[owner_o];
            mgmt_gpio_oeb_o <= oeb_s[owner_o];
            if (cnt != CNT_W'(MAX_HOLD)) cnt <= cnt + 1'b1;
          end
        end
        ST_TURN: begin
          if (turn_done) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mgmt_gpio_arbiter.sv
// Bench for mgmt_gpio_arbiter: directed vector table, corner sequences and
// randomized traffic against a behavioural ownership model.
module tb_mgmt_gpio_arbiter;

  localparam int NREQ     = 3;
  localparam int NPINS    = 3;
  localparam int TURN_CYC = 2;
  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req, gnt, gin, gout, goeb;
  logic [8:0] rout, roeb, rin;
  logic       busy, timeout;
  logic [1:0] owner;

  always #5 clk = ~clk;

  mgmt_gpio_arbiter #(
    .NREQ(NREQ), .NPINS(NPINS), .TURN_CYC(TURN_CYC), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .req_i           (req),
    .gnt_o           (gnt),
    .req_out_i       (rout),
    .req_oeb_i       (roeb),
    .req_in_o        (rin),
    .mgmt_gpio_in_i  (gin),
    .mgmt_gpio_out_o (gout),
    .mgmt_gpio_oeb_o (goeb),
    .busy_o          (busy),
    .owner_o         (owner),
    .timeout_o       (timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: who owns the pins, how many high-Z cycles remain,
  // how long the owner has held, and who was served last.
  int         m_owner, m_turn, m_held, m_last, m_owner_o;
  logic [2:0] m_out, m_oeb;
  logic       m_to;

  task automatic model_reset();
    m_owner = -1; m_turn = 0; m_held = 0; m_last = NREQ - 1; m_owner_o = 0;
    m_out = '0; m_oeb = '1; m_to = 1'b0;
  endtask

  task automatic model_step();
    logic [2:0] mask;
    bit rel, pre;
    int c;
    m_to = 1'b0;
    if (m_owner >= 0) begin
      mask = 3'(1 << m_owner);
      rel  = ((req & mask) == 3'b0);
      pre  = (MAX_HOLD != 0) && (m_held == MAX_HOLD) && ((req & ~mask) != 3'b0);
      if (rel || pre) begin
        m_owner = -1; m_turn = TURN_CYC; m_held = 0;
        m_out = '0; m_oeb = '1; m_to = !rel;
      end else begin
        m_out = 3'(rout >> (NPINS * m_owner));
        m_oeb = 3'(roeb >> (NPINS * m_owner));
        if (m_held < MAX_HOLD) m_held++;
      end
    end else if (m_turn > 0) begin
      m_turn--;
    end else if (req != 3'b0) begin
      for (int i = 1; i <= NREQ; i++) begin
        c = (m_last + i) % NREQ;
        if (m_owner < 0 && ((req >> c) & 3'b1) != 3'b0) m_owner = c;
      end
      m_last = m_owner; m_owner_o = m_owner; m_held = 0;
      m_out = 3'(rout >> (NPINS * m_owner));
      m_oeb = 3'(roeb >> (NPINS * m_owner));
    end
  endtask

  task automatic check_model(input int cyc);
    logic [2:0] e_gnt;
    logic [8:0] e_rin;
    e_gnt = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b0;
    e_rin = (m_owner >= 0) ? (9'(gin) << (NPINS * m_owner)) : 9'b0;
    check($sformatf("rand%0d gnt", cyc), 32'(gnt), 32'(e_gnt));
    check($sformatf("rand%0d out", cyc), 32'(gout), 32'(m_out));
    check($sformatf("rand%0d oeb", cyc), 32'(goeb), 32'(m_oeb));
    check($sformatf("rand%0d busy", cyc), 32'(busy), 32'(m_owner >= 0 || m_turn > 0));
    check($sformatf("rand%0d owner", cyc), 32'(owner), 32'(m_owner_o));
    check($sformatf("rand%0d timeout", cyc), 32'(timeout), 32'(m_to));
    check($sformatf("rand%0d req_in", cyc), 32'(rin), 32'(e_rin));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [2:0] req;
    logic [8:0] rout;
    logic [8:0] roeb;
    logic [2:0] e_gnt;
    logic [2:0] e_out;
    logic [2:0] e_oeb;
    logic       e_busy;
    logic [1:0] e_owner;
    logic [8:0] e_rin;
  } vec_t;

  localparam logic [8:0] OA = 9'b101_010_001;
  localparam logic [8:0] OB = 9'b011_010_001;
  localparam logic [8:0] EA = 9'b010_100_000;
  localparam logic [8:0] R0 = 9'b000_000_110;
  localparam logic [8:0] R1 = 9'b000_110_000;
  localparam logic [8:0] R2 = 9'b110_000_000;

  vec_t tbl [22];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int held, guard;
    bit lost, saw_to;

    rst = 1'b1; req = '0; rout = '0; roeb = '0; gin = '0;
    model_reset();
    #2;
    check("reset gnt", 32'(gnt), 32'h0);
    check("reset oeb", 32'(goeb), 32'h7);
    check("reset out", 32'(gout), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset owner", 32'(owner), 32'h0);
    check("reset timeout", 32'(timeout), 32'h0);
    check("reset req_in", 32'(rin), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Round-robin 0,1,2,0 with 4-cycle holds and per-slice pin tracking.
    tbl[0]  = '{3'b111, OA, EA, 3'b001, 3'b001, 3'b000, 1'b1, 2'd0, R0};
    tbl[1]  = tbl[0];
    tbl[2]  = tbl[0];
    tbl[3]  = tbl[0];
    tbl[4]  = '{3'b110, OA, EA, 3'b000, 3'b000, 3'b111, 1'b1, 2'd0, 9'd0};
    tbl[5]  = '{3'b111, OA, EA, 3'b000, 3'b000, 3'b111, 1'b1, 2'd0, 9'd0};
    tbl[6]  = '{3'b111, OA, EA, 3'b000, 3'b000, 3'b111, 1'b0, 2'd0, 9'd0};
    tbl[7]  = '{3'b111, OA, EA, 3'b010, 3'b010, 3'b100, 1'b1, 2'd1, R1};
    tbl[8]  = tbl[7];
    tbl[9]  = tbl[7];
    tbl[10] = tbl[7];
    tbl[11] = '{3'b101, OA, EA, 3'b000, 3'b000, 3'b111, 1'b1, 2'd1, 9'd0};
    tbl[12] = '{3'b111, OA, EA, 3'b000, 3'b000, 3'b111, 1'b1, 2'd1, 9'd0};
    tbl[13] = '{3'b111, OA, EA, 3'b000, 3'b000, 3'b111, 1'b0, 2'd1, 9'd0};
    tbl[14] = '{3'b111, OA, EA, 3'b100, 3'b101, 3'b010, 1'b1, 2'd2, R2};
    tbl[15] = '{3'b111, OB, EA, 3'b100, 3'b011, 3'b010, 1'b1, 2'd2, R2};
    tbl[16] = tbl[15];
    tbl[17] = tbl[15];
    tbl[18] = '{3'b011, OB, EA, 3'b000, 3'b000, 3'b111, 1'b1, 2'd2, 9'd0};
    tbl[19] = '{3'b111, OB, EA, 3'b000, 3'b000, 3'b111, 1'b1, 2'd2, 9'd0};
    tbl[20] = '{3'b111, OB, EA, 3'b000, 3'b000, 3'b111, 1'b0, 2'd2, 9'd0};
    tbl[21] = '{3'b111, OB, EA, 3'b001, 3'b001, 3'b000, 1'b1, 2'd0, R0};

    gin = 3'b110;
    for (int i = 0; i < 22; i++) begin
      req = tbl[i].req; rout = tbl[i].rout; roeb = tbl[i].roeb;
      tick();
      check($sformatf("row%0d gnt", i), 32'(gnt), 32'(tbl[i].e_gnt));
      check($sformatf("row%0d out", i), 32'(gout), 32'(tbl[i].e_out));
      check($sformatf("row%0d oeb", i), 32'(goeb), 32'(tbl[i].e_oeb));
      check($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
      check($sformatf("row%0d owner", i), 32'(owner), 32'(tbl[i].e_owner));
      check($sformatf("row%0d timeout", i), 32'(timeout), 32'h0);
      check($sformatf("row%0d req_in", i), 32'(rin), 32'(tbl[i].e_rin));
    end

    // Asynchronous reset while requester 1 drives the pins.
    do_reset();
    req = 3'b010; rout = OA; roeb = EA;
    tick();
    check("rstseq gnt", 32'(gnt), 32'h2);
    check("rstseq out", 32'(gout), 32'h2);
    #1 rst = 1'b1;
    #1;
    check("rstseq async oeb", 32'(goeb), 32'h7);
    check("rstseq async out", 32'(gout), 32'h0);
    check("rstseq async gnt", 32'(gnt), 32'h0);
    check("rstseq async busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    req = 3'b111;
    tick();
    check("rstseq first gnt", 32'(gnt), 32'h1);

    // Pre-emption: the counter reaches MAX_HOLD after MAX_HOLD edges in
    // GRANT, and the following edge pre-empts, so gnt is seen MAX_HOLD+1 cycles.
    do_reset();
    req = 3'b001;
    tick();
    check("pre gnt0", 32'(gnt), 32'h1);
    held = 1;
    repeat (2) begin
      tick();
      if (gnt == 3'b001) held++;
    end
    req = 3'b011;
    guard = 0;
    while (gnt == 3'b001 && guard < 40) begin
      tick();
      guard++;
      if (gnt == 3'b001) held++;
    end
    check("pre bound", 32'(guard < 40), 32'h1);
    check("pre held cycles", 32'(held), 32'(MAX_HOLD + 1));
    check("pre timeout pulse", 32'(timeout), 32'h1);
    check("pre turn oeb", 32'(goeb), 32'h7);
    tick();
    check("pre timeout drop", 32'(timeout), 32'h0);
    check("pre turn gnt", 32'(gnt), 32'h0);
    tick();
    check("pre idle busy", 32'(busy), 32'h0);
    tick();
    check("pre next gnt", 32'(gnt), 32'h2);

    // Release and pre-emption land on the same edge.
    repeat (MAX_HOLD) tick();
    check("relpre still owned", 32'(gnt), 32'h2);
    req = 3'b001;
    tick();
    check("relpre gnt", 32'(gnt), 32'h0);
    check("relpre timeout", 32'(timeout), 32'h0);
    tick();
    check("relpre timeout later", 32'(timeout), 32'h0);

    // Saturated hold with no contender keeps ownership.
    do_reset();
    req = 3'b100;
    tick();
    check("sat gnt", 32'(gnt), 32'h4);
    lost = 0; saw_to = 0;
    repeat (30) begin
      tick();
      if (gnt != 3'b100) lost = 1;
      if (timeout) saw_to = 1;
    end
    check("sat retained", 32'(lost), 32'h0);
    check("sat no timeout", 32'(saw_to), 32'h0);
    req = 3'b110;
    tick();
    check("sat contender gnt", 32'(gnt), 32'h0);
    check("sat contender timeout", 32'(timeout), 32'h1);

    // Randomized traffic against the model.
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      req  = 3'($urandom) & 3'($urandom);
      if (m_owner >= 0 && $urandom_range(0, 15) != 0) req = req | 3'(1 << m_owner);
      rout = 9'($urandom);
      roeb = 9'($urandom);
      gin  = 3'($urandom);
      tick();
      check_model(cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
